// File: rtl/peripheral_irq_flags.sv
// Multi-channel peripheral interrupt flag bank: synchronised event lines latch
// per-channel pending/overflow flags and drive a prioritised request to an 8259A-style IR input.
module peripheral_irq_flags #(
    parameter int NUM_CH      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] event_in,
    input  logic [NUM_CH-1:0] edge_mode,
    input  logic [NUM_CH-1:0] mask,
    input  logic              clr_valid,
    input  logic [NUM_CH-1:0] clr_bits,
    input  logic              ack,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] overflow,
    output logic              irq,
    output logic [ID_W-1:0]   irq_id
);

    logic [NUM_CH-1:0] sync_reg [SYNC_STAGES];
    logic [NUM_CH-1:0] prev_reg;
    logic [NUM_CH-1:0] pending_reg;
    logic [NUM_CH-1:0] overflow_reg;
    logic              irq_reg;
    logic [ID_W-1:0]   irq_id_reg;

    logic [NUM_CH-1:0] s;
    logic [NUM_CH-1:0] set_c;
    logic [NUM_CH-1:0] w1c_c;
    logic [NUM_CH-1:0] clr_c;
    logic [NUM_CH-1:0] active;
    logic [ID_W-1:0]   id_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_reg[k] <= '0;
            end
        end else begin
            sync_reg[0] <= event_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_reg[k] <= sync_reg[k-1];
            end
        end
    end

    assign s = sync_reg[SYNC_STAGES-1];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign set_c[gi] = edge_mode[gi] ? (s[gi] & ~prev_reg[gi]) : s[gi];
            assign w1c_c[gi] = clr_valid & clr_bits[gi];
            // Ack targets the request the controller actually saw this cycle.
            assign clr_c[gi] = w1c_c[gi] | (ack & irq_reg & (irq_id_reg == ID_W'(gi)));

            // prev tracks s in both modes so switching mode never creates an edge.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prev_reg[gi]     <= 1'b0;
                    pending_reg[gi]  <= 1'b0;
                    overflow_reg[gi] <= 1'b0;
                end else begin
                    prev_reg[gi] <= s[gi];
                    if (set_c[gi]) begin
                        pending_reg[gi] <= 1'b1;
                    end else if (clr_c[gi]) begin
                        pending_reg[gi] <= 1'b0;
                    end
                    if (edge_mode[gi] && set_c[gi] && pending_reg[gi] && !clr_c[gi]) begin
                        overflow_reg[gi] <= 1'b1;
                    end else if (w1c_c[gi]) begin
                        overflow_reg[gi] <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    assign active = pending_reg & ~mask;

    // Descending scan leaves the lowest active index as the winner.
    always_comb begin
        id_next = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (active[i]) begin
                id_next = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_reg    <= 1'b0;
            irq_id_reg <= '0;
        end else begin
            irq_reg    <= |active;
            irq_id_reg <= id_next;
        end
    end

    assign pending  = pending_reg;
    assign overflow = overflow_reg;
    assign irq      = irq_reg;
    assign irq_id   = irq_id_reg;

endmodule

// File: tb/tb_peripheral_irq_flags.sv
// Directed self-checking bench for peripheral_irq_flags (NUM_CH=8, SYNC_STAGES=2).
module tb_peripheral_irq_flags;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] event_in;
    logic [7:0] edge_mode;
    logic [7:0] mask;
    logic       clr_valid;
    logic [7:0] clr_bits;
    logic       ack;
    logic [7:0] pending;
    logic [7:0] overflow;
    logic       irq;
    logic [2:0] irq_id;

    int checks_cnt   = 0;
    int failures_cnt = 0;

    peripheral_irq_flags #(
        .NUM_CH(8),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .event_in(event_in),
        .edge_mode(edge_mode),
        .mask(mask),
        .clr_valid(clr_valid),
        .clr_bits(clr_bits),
        .ack(ack),
        .pending(pending),
        .overflow(overflow),
        .irq(irq),
        .irq_id(irq_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_cnt++;
        if (observed !== expected) begin
            failures_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end else begin
            $display("ok   %s: 0x%0h", tag, observed);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic w1c(input logic [7:0] bits);
        clr_valid = 1'b1;
        clr_bits  = bits;
        tick(1);
        clr_valid = 1'b0;
        clr_bits  = 8'h00;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        event_in  = 8'h00;
        edge_mode = 8'hFF;
        mask      = 8'h00;
        clr_valid = 1'b0;
        clr_bits  = 8'h00;
        ack       = 1'b0;

        // Reset state
        tick(3);
        check("rst_pending", pending, 8'h00);
        check("rst_overflow", overflow, 8'h00);
        check("rst_irq", irq, 1'b0);
        check("rst_irq_id", irq_id, 3'd0);
        rst_n = 1'b1;
        tick(2);

        // Edge latch on channel 3 with latency
        event_in[3] = 1'b1;
        tick(2);
        check("ch3_not_yet", pending, 8'h00);
        tick(1);
        check("ch3_pending", pending, 8'h08);
        check("ch3_irq_early", irq, 1'b0);
        tick(1);
        check("ch3_irq", irq, 1'b1);
        check("ch3_irq_id", irq_id, 3'd3);
        check("ch3_overflow", overflow, 8'h00);
        event_in[3] = 1'b0;
        w1c(8'h08);
        check("ch3_cleared", pending, 8'h00);
        tick(1);
        check("ch3_irq_drop", irq, 1'b0);
        tick(2);

        // Priority and ack
        event_in[5] = 1'b1;
        event_in[2] = 1'b1;
        tick(4);
        check("pri_pending", pending, 8'h24);
        check("pri_id2", irq_id, 3'd2);
        do_ack();
        check("ack1_pending", pending, 8'h20);
        check("ack1_stale_id", irq_id, 3'd2);
        tick(1);
        check("ack1_irq", irq, 1'b1);
        check("ack1_id5", irq_id, 3'd5);
        do_ack();
        check("ack2_pending", pending, 8'h00);
        tick(1);
        check("ack2_irq", irq, 1'b0);
        check("ack2_id", irq_id, 3'd0);
        do_ack();
        check("ack_idle_pending", pending, 8'h00);
        event_in[5] = 1'b0;
        event_in[2] = 1'b0;
        tick(3);

        // Mask
        mask = 8'h02;
        event_in[1] = 1'b1;
        tick(4);
        check("mask_pending", pending, 8'h02);
        check("mask_irq", irq, 1'b0);
        mask = 8'h00;
        tick(1);
        check("unmask_irq", irq, 1'b1);
        check("unmask_id", irq_id, 3'd1);
        mask = 8'h02;
        tick(1);
        check("remask_irq", irq, 1'b0);
        mask = 8'h00;
        event_in[1] = 1'b0;
        w1c(8'h02);
        check("mask_clr", pending, 8'h00);
        tick(3);

        // Level mode on channel 4: input high keeps pending despite W1C
        edge_mode = 8'hEF;
        event_in[4] = 1'b1;
        tick(3);
        check("lvl_pending", pending, 8'h10);
        w1c(8'h10);
        check("lvl_clr_held", pending, 8'h10);
        event_in[4] = 1'b0;
        tick(3);
        w1c(8'h10);
        check("lvl_clr_low", pending, 8'h00);
        check("lvl_no_ovf", overflow, 8'h00);
        tick(1);

        // Same sequence in edge mode: clear works while input is high
        edge_mode = 8'hFF;
        event_in[4] = 1'b1;
        tick(3);
        check("edg4_pending", pending, 8'h10);
        w1c(8'h10);
        check("edg4_clr_high", pending, 8'h00);
        tick(2);
        check("edg4_stays_clr", pending, 8'h00);
        event_in[4] = 1'b0;
        tick(3);

        // Overflow and set-vs-clear on channel 0
        event_in[0] = 1'b1;
        tick(3);
        check("ovf_first", pending, 8'h01);
        event_in[0] = 1'b0;
        tick(3);
        event_in[0] = 1'b1;
        tick(3);
        check("ovf_set", overflow, 8'h01);
        do_ack();
        check("ovf_ack_keeps", overflow, 8'h01);
        check("ovf_ack_pending", pending, 8'h00);
        event_in[0] = 1'b0;
        tick(3);
        event_in[0] = 1'b1;
        tick(3);
        check("ovf_repend", pending, 8'h01);
        w1c(8'h01);
        check("w1c_pending", pending, 8'h00);
        check("w1c_overflow", overflow, 8'h00);
        event_in[0] = 1'b0;
        tick(3);
        event_in[0] = 1'b1;
        tick(2);
        w1c(8'h01);
        check("setwins_pending", pending, 8'h01);
        check("setwins_overflow", overflow, 8'h00);

        // Reset mid-operation
        event_in = 8'h00;
        tick(3);
        event_in = 8'hFF;
        tick(3);
        check("all_pending", pending, 8'hFF);
        check("all_overflow", overflow, 8'h01);
        tick(1);
        check("all_irq_id", irq_id, 3'd0);
        #2 rst_n = 1'b0;
        #2;
        check("arst_pending", pending, 8'h00);
        check("arst_overflow", overflow, 8'h00);
        check("arst_irq", irq, 1'b0);
        check("arst_irq_id", irq_id, 3'd0);
        #1 rst_n = 1'b1;
        tick(2);
        check("relatch_wait", pending, 8'h00);
        tick(1);
        check("relatch_pending", pending, 8'hFF);
        check("relatch_overflow", overflow, 8'h00);
        tick(1);
        check("relatch_irq", irq, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule
